regfile_nx_w: RTL and testbench
===============================

# regfile_nx_w

Parametrised successor to the 16x32 Mini-SRC register file. It has WIDTH-bit entries, DEPTH entries, one write port (C) and two registered read ports (A, B) with write-to-read bypass, and it keeps R0 base-address gating on port A. Reset runs a sequential clear sweep through the single write port, so the array maps onto RAM-style storage; `out_ready` reports when the file is usable. It sits in the datapath between the bus/ALU result path (C) and the operand latches (A, B).

## Interface
- `WIDTH`, 32, entry width in bits.
- `DEPTH`, 16, number of entries; 2..256, power of two not required.
- `AW`, $clog2(DEPTH), select width (derived; do not override).
- `BA_GATE`, 1, when 1, `in_BAout` forces port-A reads of entry 0 to zero.
- `in_clk`  in  1  clock, all state changes on rising edge.
- `in_clr`  in  1  reset; synchronous and active-high.
- `in_Cdata`  in  WIDTH  write data.
- `in_Cselect`  in  AW  write address.
- `in_write`  in  1  write strobe.
- `in_Aselect`  in  AW  port-A read address.
- `in_Bselect`  in  AW  port-B read address.
- `in_read`  in  1  read strobe, captures both ports.
- `in_BAout`  in  1  base-address mode for port A.
- `out_Adata`  out  WIDTH  port-A registered read data.
- `out_Bdata`  out  WIDTH  port-B registered read data.
- `out_valid`  out  1  read data updated by the previous edge.
- `out_ready`  out  1  sweep done; reads and writes are accepted.

## Operation
- **States:** SWEEP and IDLE.
- **Reset (`in_clr`=1 at an edge):**
  - state goes to SWEEP and the sweep index goes to 0.
  - `out_Adata`=0, `out_Bdata`=0, `out_valid`=0, `out_ready`=0.
  - Array contents are not touched by the reset edge itself.
- **SWEEP:**
  - Each edge with `in_clr`=0 writes 0 to entry[index], then index+1.
  - The edge that clears entry DEPTH-1 moves the state to IDLE and sets `out_ready`=1.
  - `in_write` and `in_read` are ignored; `out_valid` stays 0.
- **Reset mid-sweep:** restarts the sweep at index 0. Nothing else changes.
- **IDLE writes:** when `in_write`=1 and `in_Cselect`<DEPTH, entry[Cselect] gets `in_Cdata` at the edge. When `in_Cselect`≥DEPTH, the write is dropped.
- **IDLE reads:** when `in_read`=1, the edge loads both outputs and sets `out_valid`=1.
  - Each port loads its selected entry.
  - Bypass (write-first): if `in_write`=1 in the same cycle and the select equals `in_Cselect`, that port loads `in_Cdata`.
  - Out-of-range select loads 0.
  - BA gate: when `BA_GATE`=1, `in_BAout`=1 and `in_Aselect`=0, `out_Adata` loads 0. This overrides bypass. Port B is never gated.
- **No read:** when `in_read`=0, the outputs hold their value and `out_valid`=0 at the next edge.
- **Same address on A and B:** both ports return identical data (bypass included).

## Timing
- **Read latency:** 1 cycle. Strobe sampled at edge N; data and `out_valid` are visible after edge N and stay stable until edge N+1.
- **Write visibility:** visible to a read at the same edge through bypass, and to the array from edge N+1 onward.
- **Sweep length:** exactly DEPTH edges with `in_clr`=0. `out_ready` rises after the DEPTH-th such edge. The first accepted access is on the next edge.
- **Output encoding:** all outputs are registered and there are no combinational paths from inputs to outputs. No X is ever driven.

## Structure
- **Package `regfile_pkg`:**
  - state enum {SWEEP, IDLE};
  - default WIDTH/DEPTH constants;
  - `BA_ZERO_SEL`=0.
- **Sub-module `regfile_sweep_ctrl`:**
  - contains the FSM and the AW-bit sweep counter;
  - outputs `sweep_we`, `sweep_addr` and `ready`.
  - The top muxes sweep vs. port-C write into the storage array and holds the read registers and bypass logic.

## Test plan
- **Reset sweep:** hold `in_clr` for 3 cycles, then release; DEPTH=16.
  - `out_ready`=0 for 16 edges, then 1.
  - A read of any entry returns 0x00000000.
- **Write then read:** write 0x11111111 to R0, then 0x11110000 to R0, then 0x11111111 to R1. Read A=R0, B=R1.
  - Result: A=0x11110000, B=0x11111111, `out_valid` high for one cycle.
- **Bypass:** in the same cycle, write 0xDEADBEEF to R5 and read A=R5, B=R5.
  - Both outputs are 0xDEADBEEF after that edge.
- **BA gate:** R0=0xCAFE0001, `in_BAout`=1, read A=R0, B=R0.
  - A=0, B=0xCAFE0001.
  - Repeat with `BA_GATE`=0: A=0xCAFE0001.
- **Reset mid-sweep:** assert `in_clr` at sweep index 7.
  - `out_ready` rises 16 edges after release, not 9.
  - Writes issued during the sweep are lost (readback 0).
- **Non-power-of-two:** DEPTH=12.
  - A write to address 13 is dropped; a read of address 13 returns 0.
  - Sweep takes 12 edges.

Source files
------------

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types and constants for the parametrised register file
package regfile_pkg;

    typedef enum logic {
        SWEEP = 1'b0,
        IDLE  = 1'b1
    } state_t;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_DEPTH = 16;
    localparam int BA_ZERO_SEL   = 0;

endpackage

// File: rtl/regfile_sweep_ctrl.sv
// rtl/regfile_sweep_ctrl.sv - post-reset clear sweep: walks every entry once through the write port
module regfile_sweep_ctrl
    import regfile_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          clr,
    output logic          sweep_we,
    output logic [AW-1:0] sweep_addr,
    output logic          ready
);

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    state_t        state;
    logic [AW-1:0] idx;

    always_ff @(posedge clk) begin
        if (clr) begin
            state <= SWEEP;
            idx   <= '0;
            ready <= 1'b0;
        end else if (state == SWEEP) begin
            if (idx == LAST) begin
                state <= IDLE;
                idx   <= '0;
                ready <= 1'b1;
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

    // A reset edge must leave the array untouched, so the clear write is masked by clr.
    assign sweep_we   = (state == SWEEP) && !clr;
    assign sweep_addr = idx;

endmodule

// File: rtl/regfile_nx_w.sv
// rtl/regfile_nx_w.sv - WIDTH x DEPTH register file, one write port, two registered read ports with bypass
module regfile_nx_w
    import regfile_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int DEPTH   = DEFAULT_DEPTH,
    parameter int AW      = $clog2(DEPTH),
    parameter int BA_GATE = 1
) (
    input  logic             in_clk,
    input  logic             in_clr,
    input  logic [WIDTH-1:0] in_Cdata,
    input  logic [AW-1:0]    in_Cselect,
    input  logic             in_write,
    input  logic [AW-1:0]    in_Aselect,
    input  logic [AW-1:0]    in_Bselect,
    input  logic             in_read,
    input  logic             in_BAout,
    output logic [WIDTH-1:0] out_Adata,
    output logic [WIDTH-1:0] out_Bdata,
    output logic             out_valid,
    output logic             out_ready
);

    localparam logic [AW:0] DEPTH_LIM = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic             sweep_we;
    logic [AW-1:0]    sweep_addr;
    logic             ready;
    logic             c_ok;
    logic             a_in, b_in, a_gate;
    logic [WIDTH-1:0] a_next, b_next;

    regfile_sweep_ctrl #(.DEPTH(DEPTH), .AW(AW)) u_sweep (
        .clk        (in_clk),
        .clr        (in_clr),
        .sweep_we   (sweep_we),
        .sweep_addr (sweep_addr),
        .ready      (ready)
    );

    assign c_ok   = ready && !in_clr && in_write && ({1'b0, in_Cselect} < DEPTH_LIM);
    assign a_in   = {1'b0, in_Aselect} < DEPTH_LIM;
    assign b_in   = {1'b0, in_Bselect} < DEPTH_LIM;
    assign a_gate = (BA_GATE != 0) && in_BAout && (in_Aselect == AW'(BA_ZERO_SEL));

    always_ff @(posedge in_clk) begin
        if (sweep_we) begin
            mem[sweep_addr] <= '0;
        end else if (c_ok) begin
            mem[in_Cselect] <= in_Cdata;
        end
    end

    // Write-first bypass; the base-address gate wins over it on port A.
    always_comb begin
        a_next = '0;
        b_next = '0;
        if (a_in && !a_gate) begin
            a_next = (c_ok && in_Aselect == in_Cselect) ? in_Cdata : mem[in_Aselect];
        end
        if (b_in) begin
            b_next = (c_ok && in_Bselect == in_Cselect) ? in_Cdata : mem[in_Bselect];
        end
    end

    always_ff @(posedge in_clk) begin
        if (in_clr) begin
            out_Adata <= '0;
            out_Bdata <= '0;
            out_valid <= 1'b0;
        end else if (ready && in_read) begin
            out_Adata <= a_next;
            out_Bdata <= b_next;
            out_valid <= 1'b1;
        end else begin
            out_valid <= 1'b0;
        end
    end

    assign out_ready = ready;

endmodule

// File: tb/tb_regfile_nx_w.sv
// tb/tb_regfile_nx_w.sv - scoreboard bench: three configurations driven in lockstep
module tb_regfile_nx_w;

    logic        clk = 1'b0;
    logic        clr, write, read, baout;
    logic [31:0] cdata;
    logic [3:0]  csel, asel, bsel;
    logic [31:0] a16, b16, a0, b0, a12, b12;
    logic        v16, v0, v12, r16, r0, r12;

    int checks = 0;
    int passed = 0;
    int cyc = 0;

    logic [31:0] m16 [16];
    logic [31:0] m12 [16];

    typedef struct {
        int          due;
        logic [31:0] a16, b16, a0, b0, a12, b12;
    } exp_t;
    exp_t q[$];
    exp_t mon_e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    regfile_nx_w #(.WIDTH(32), .DEPTH(16), .BA_GATE(1)) dut16 (
        .in_clk(clk), .in_clr(clr), .in_Cdata(cdata), .in_Cselect(csel), .in_write(write),
        .in_Aselect(asel), .in_Bselect(bsel), .in_read(read), .in_BAout(baout),
        .out_Adata(a16), .out_Bdata(b16), .out_valid(v16), .out_ready(r16));

    regfile_nx_w #(.WIDTH(32), .DEPTH(16), .BA_GATE(0)) dut0 (
        .in_clk(clk), .in_clr(clr), .in_Cdata(cdata), .in_Cselect(csel), .in_write(write),
        .in_Aselect(asel), .in_Bselect(bsel), .in_read(read), .in_BAout(baout),
        .out_Adata(a0), .out_Bdata(b0), .out_valid(v0), .out_ready(r0));

    regfile_nx_w #(.WIDTH(32), .DEPTH(12), .BA_GATE(1)) dut12 (
        .in_clk(clk), .in_clr(clr), .in_Cdata(cdata), .in_Cselect(csel), .in_write(write),
        .in_Aselect(asel), .in_Bselect(bsel), .in_read(read), .in_BAout(baout),
        .out_Adata(a12), .out_Bdata(b12), .out_valid(v12), .out_ready(r12));

    function automatic logic [31:0] model_rd(input bit d12, input bit gate, input bit is_a,
                                             input logic [3:0] sel);
        int depth = d12 ? 12 : 16;
        if (int'(sel) >= depth) return 32'h0;
        if (is_a && gate && baout && sel == 4'd0) return 32'h0;
        if (write && csel == sel) return cdata;
        return d12 ? m12[sel] : m16[sel];
    endfunction

    task automatic step();
        exp_t e;
        if (read && r16) begin
            e.due = cyc + 1;
            e.a16 = model_rd(1'b0, 1'b1, 1'b1, asel);
            e.b16 = model_rd(1'b0, 1'b1, 1'b0, bsel);
            e.a0  = model_rd(1'b0, 1'b0, 1'b1, asel);
            e.b0  = model_rd(1'b0, 1'b0, 1'b0, bsel);
            e.a12 = model_rd(1'b1, 1'b1, 1'b1, asel);
            e.b12 = model_rd(1'b1, 1'b1, 1'b0, bsel);
            q.push_back(e);
        end
        @(posedge clk);
        if (write && r16 && !clr) begin
            m16[csel] = cdata;
            if (csel < 4'd12) m12[csel] = cdata;
        end
        #1;
    endtask

    always @(negedge clk) begin
        if (cyc > 0) begin
            if (q.size() > 0 && q[0].due == cyc) begin
                mon_e = q.pop_front();
                checks++; if (a16 !== mon_e.a16) $display("FAIL rd_a16 got %h exp %h cyc %0d", a16, mon_e.a16, cyc); else passed++;
                checks++; if (b16 !== mon_e.b16) $display("FAIL rd_b16 got %h exp %h cyc %0d", b16, mon_e.b16, cyc); else passed++;
                checks++; if (a0 !== mon_e.a0) $display("FAIL rd_a_nogate got %h exp %h cyc %0d", a0, mon_e.a0, cyc); else passed++;
                checks++; if (b0 !== mon_e.b0) $display("FAIL rd_b_nogate got %h exp %h cyc %0d", b0, mon_e.b0, cyc); else passed++;
                checks++; if (a12 !== mon_e.a12) $display("FAIL rd_a12 got %h exp %h cyc %0d", a12, mon_e.a12, cyc); else passed++;
                checks++; if (b12 !== mon_e.b12) $display("FAIL rd_b12 got %h exp %h cyc %0d", b12, mon_e.b12, cyc); else passed++;
                checks++;
                if ({v16, v0, v12} !== 3'b111) $display("FAIL valid_high got %b exp 111 cyc %0d", {v16, v0, v12}, cyc);
                else passed++;
            end else begin
                checks++;
                if ({v16, v0, v12} !== 3'b000) $display("FAIL valid_low got %b exp 000 cyc %0d", {v16, v0, v12}, cyc);
                else passed++;
            end
        end
    end

    task automatic sweep_count(input bit wr_during, output int t16, output int t12);
        t16 = 0;
        t12 = 0;
        for (int e = 1; e <= 40; e++) begin
            write = wr_during && (e < 10);
            csel  = 4'd3;
            cdata = 32'hBAD0_0003;
            @(posedge clk);
            #1;
            if (r12 && t12 == 0) t12 = e;
            if (r16 && t16 == 0) t16 = e;
            if (t16 != 0 && t12 != 0) break;
        end
        write = 1'b0;
        for (int i = 0; i < 16; i++) begin
            m16[i] = 32'h0;
            m12[i] = 32'h0;
        end
    endtask

    task automatic test_reset();
        int t16, t12;
        clr = 1'b1; write = 1'b0; read = 1'b0; baout = 1'b0;
        cdata = 32'h0; csel = 4'd0; asel = 4'd0; bsel = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (a16 !== 32'h0 || b16 !== 32'h0) $display("FAIL reset_data got %h/%h exp 0/0", a16, b16); else passed++;
        checks++; if ({r16, r0, r12} !== 3'b000) $display("FAIL reset_ready got %b exp 000", {r16, r0, r12}); else passed++;
        clr = 1'b0;
        sweep_count(1'b0, t16, t12);
        checks++; if (t16 != 16) $display("FAIL sweep_len16 got %0d exp 16", t16); else passed++;
        checks++; if (t12 != 12) $display("FAIL sweep_len12 got %0d exp 12", t12); else passed++;
        checks++; if (r0 !== 1'b1) $display("FAIL ready_nogate got %b exp 1", r0); else passed++;
        for (int i = 0; i < 16; i++) begin
            read = 1'b1; asel = 4'(i); bsel = 4'(15 - i);
            step();
        end
        read = 1'b0;
        step();
    endtask

    task automatic test_write_read();
        write = 1'b1; csel = 4'd0; cdata = 32'h1111_1111; step();
        cdata = 32'h1111_0000; step();
        csel = 4'd1; cdata = 32'h1111_1111; step();
        write = 1'b0; read = 1'b1; asel = 4'd0; bsel = 4'd1; step();
        read = 1'b0; step(); step();
    endtask

    task automatic test_bypass();
        write = 1'b1; csel = 4'd5; cdata = 32'hDEAD_BEEF;
        read = 1'b1; asel = 4'd5; bsel = 4'd5; step();
        write = 1'b0; step();
        read = 1'b0; step();
    endtask

    task automatic test_ba_gate();
        write = 1'b1; csel = 4'd0; cdata = 32'hCAFE_0001; step();
        write = 1'b0; baout = 1'b1; read = 1'b1; asel = 4'd0; bsel = 4'd0; step();
        write = 1'b1; cdata = 32'h1234_5678; step();
        write = 1'b0; baout = 1'b0; step();
        read = 1'b0; step();
    endtask

    task automatic test_non_pow2();
        write = 1'b1; csel = 4'd13; cdata = 32'h1313_1313; step();
        write = 1'b0; read = 1'b1; asel = 4'd13; bsel = 4'd11; step();
        write = 1'b1; csel = 4'd12; cdata = 32'h1212_1212; asel = 4'd12; bsel = 4'd13; step();
        write = 1'b0; asel = 4'd11; bsel = 4'd12; step();
        read = 1'b0; step();
    endtask

    task automatic test_mid_sweep();
        int t16, t12;
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0; write = 1'b1; csel = 4'd3; cdata = 32'hBAD0_0003;
        repeat (7) @(posedge clk);
        #1;
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        sweep_count(1'b1, t16, t12);
        checks++; if (t16 != 16) $display("FAIL midsweep_len16 got %0d exp 16", t16); else passed++;
        checks++; if (t12 != 12) $display("FAIL midsweep_len12 got %0d exp 12", t12); else passed++;
        read = 1'b1; asel = 4'd3; bsel = 4'd0; step();
        read = 1'b0; step();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 40; i++) begin
            write = 1'($urandom_range(0, 1));
            csel  = 4'($urandom_range(0, 15));
            cdata = $urandom;
            read  = 1'($urandom_range(0, 1));
            asel  = 4'($urandom_range(0, 15));
            bsel  = (i % 3 == 0) ? csel : 4'($urandom_range(0, 15));
            baout = 1'($urandom_range(0, 1));
            step();
        end
        write = 1'b0; read = 1'b0; baout = 1'b0;
        step(); step();
        checks++; if (q.size() != 0) $display("FAIL scoreboard_drain got %0d exp 0", q.size()); else passed++;
    endtask

    initial begin
        clr = 1'b1;
        test_reset();
        test_write_read();
        test_bypass();
        test_ba_gate();
        test_non_pow2();
        test_mid_sweep();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
